// File: rtl/ysyx_22041211_pkg.sv
// ysyx_22041211_pkg
//   Shared defaults for the NPC register file slice.
//   DEF_DATA_WIDTH : default register width in bits
//   DEF_NUM_REGS   : default architectural register count
//   REG_ZERO       : address of the hardwired-zero register
package ysyx_22041211_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_NUM_REGS   = 32;
  localparam int unsigned REG_ZERO       = 0;

endpackage

// File: rtl/ysyx_22041211_scoreboard.sv
// ysyx_22041211_scoreboard
//   Per-register busy bits tracking one outstanding producer each.
//   Ports:
//     clk, rst        : clock, asynchronous active-low reset
//     wen, waddr      : writeback retiring a producer
//     alloc_en/addr   : decode allocating a destination
//     flush           : clears every busy bit
//     busy_vec        : registered busy state, one bit per register
module ysyx_22041211_scoreboard
  import ysyx_22041211_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wen,
  input  logic [AW-1:0]       waddr,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;

  // Priority: flush, then allocation (new producer wins over a same-cycle
  // retirement), then retirement. Register zero is never allocated.
  always_comb begin
    busy_nxt = busy_q;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (alloc_en && (alloc_addr == AW'(r)) && (r != REG_ZERO)) begin
          busy_nxt[r] = 1'b1;
        end else if (wen && (waddr == AW'(r))) begin
          busy_nxt[r] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/ysyx_22041211_regfile_sb.sv
// ysyx_22041211_regfile_sb
//   Multi-read-port integer register file with write-through bypass and a
//   busy scoreboard. Register zero reads as zero and is never busy.
//   Ports:
//     clk, rst          : clock, asynchronous active-low reset
//     wen/waddr/wdata   : writeback port
//     raddr/rdata/rbusy : NUM_RD combinational read ports (packed, port i
//                         at the i-th slice)
//     alloc_en/addr     : destination allocation from decode
//     flush             : clears scoreboard
//     busy_vec          : raw scoreboard state
module ysyx_22041211_regfile_sb
  import ysyx_22041211_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int unsigned NUM_REGS   = DEF_NUM_REGS,
  parameter  int unsigned NUM_RD     = 2,
  localparam int unsigned AW         = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wen,
  input  logic [AW-1:0]                waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [NUM_RD*AW-1:0]         raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic                         alloc_en,
  input  logic [AW-1:0]                alloc_addr,
  input  logic                         flush,
  output logic [NUM_REGS-1:0]          busy_vec
);

  logic [DATA_WIDTH-1:0] rf [NUM_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else if (wen && (waddr != AW'(REG_ZERO))) begin
      rf[waddr] <= wdata;
    end
  end

  ysyx_22041211_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wen        (wen),
    .waddr      (waddr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .busy_vec   (busy_vec)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    logic          is_zero;

    assign ra      = raddr[i*AW +: AW];
    assign is_zero = (ra == AW'(REG_ZERO));
    assign hit     = wen && (waddr == ra);

    // A same-cycle writeback both forwards its data and retires the
    // producer, so the reader neither sees stale data nor stalls.
    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = is_zero ? '0 :
                                               hit     ? wdata : rf[ra];
    assign rbusy[i] = !is_zero && busy_vec[ra] && !hit;
  end

endmodule

// File: tb/tb_ysyx_22041211_regfile_sb.sv
module tb_ysyx_22041211_regfile_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned ND = 2;
  localparam int unsigned AW = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             wen;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic [ND*AW-1:0] raddr;
  logic [ND*DW-1:0] rdata;
  logic [ND-1:0]    rbusy;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic             flush;
  logic [NR-1:0]    busy_vec;

  typedef struct {
    string         tag;
    logic [ND*DW-1:0] rdata;
    logic [ND-1:0] rbusy;
    logic [NR-1:0] busy_vec;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_asserts = 0;
  int   n_fail    = 0;

  ysyx_22041211_regfile_sb #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .NUM_RD     (ND)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr      (raddr),
    .rdata      (rdata),
    .rbusy      (rbusy),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .busy_vec   (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic idle();
    wen = 1'b0; waddr = '0; wdata = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] p1, input logic [AW-1:0] p0);
    raddr = {p1, p0};
  endtask

  task automatic push(input string tag, input logic [DW-1:0] d1, input logic [DW-1:0] d0,
                      input logic [ND-1:0] rb, input logic [NR-1:0] bv);
    exp_t x;
    x.tag = tag; x.rdata = {d1, d0}; x.rbusy = rb; x.busy_vec = bv;
    exp_q.push_back(x);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle(); rd(5'd0, 5'd5);
    push("reset_hold", 32'h0, 32'h0, 2'b00, 32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); n_asserts++;
    if ({rdata, rbusy, busy_vec} !== {e.rdata, e.rbusy, e.busy_vec}) begin n_fail++;
      $display("FAIL %s: got rdata=%h rbusy=%b busy_vec=%h, want rdata=%h rbusy=%b busy_vec=%h", e.tag, rdata, rbusy, busy_vec, e.rdata, e.rbusy, e.busy_vec); end
    next_cycle();
    rst = 1'b1;
    push("reset_release", 32'h0, 32'h0, 2'b00, 32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); n_asserts++;
    if ({rdata, rbusy, busy_vec} !== {e.rdata, e.rbusy, e.busy_vec}) begin n_fail++;
      $display("FAIL %s: got rdata=%h rbusy=%b busy_vec=%h, want rdata=%h rbusy=%b busy_vec=%h", e.tag, rdata, rbusy, busy_vec, e.rdata, e.rbusy, e.busy_vec); end
    next_cycle();
  endtask

  task automatic test_write_bypass();
    wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; rd(5'd0, 5'd5);
    push("bypass", 32'h0, 32'hDEADBEEF, 2'b00, 32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); n_asserts++;
    if ({rdata, rbusy, busy_vec} !== {e.rdata, e.rbusy, e.busy_vec}) begin n_fail++;
      $display("FAIL %s: got rdata=%h rbusy=%b busy_vec=%h, want rdata=%h rbusy=%b busy_vec=%h", e.tag, rdata, rbusy, busy_vec, e.rdata, e.rbusy, e.busy_vec); end
    next_cycle();
    idle(); rd(5'd5, 5'd5);
    push("write_stored", 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); n_asserts++;
    if ({rdata, rbusy, busy_vec} !== {e.rdata, e.rbusy, e.busy_vec}) begin n_fail++;
      $display("FAIL %s: got rdata=%h rbusy=%b busy_vec=%h, want rdata=%h rbusy=%b busy_vec=%h", e.tag, rdata, rbusy, busy_vec, e.rdata, e.rbusy, e.busy_vec); end
    next_cycle();
  endtask

  task automatic test_reg_zero();
    wen = 1'b1; waddr = 5'd0; wdata = 32'h1234;
    alloc_en = 1'b1; alloc_addr = 5'd0; rd(5'd0, 5'd0);
    push("r0_same_cycle", 32'h0, 32'h0, 2'b00, 32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); n_asserts++;
    if ({rdata, rbusy, busy_vec} !== {e.rdata, e.rbusy, e.busy_vec}) begin n_fail++;
      $display("FAIL %s: got rdata=%h rbusy=%b busy_vec=%h, want rdata=%h rbusy=%b busy_vec=%h", e.tag, rdata, rbusy, busy_vec, e.rdata, e.rbusy, e.busy_vec); end
    next_cycle();
    idle();
    push("r0_after", 32'h0, 32'h0, 2'b00, 32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); n_asserts++;
    if ({rdata, rbusy, busy_vec} !== {e.rdata, e.rbusy, e.busy_vec}) begin n_fail++;
      $display("FAIL %s: got rdata=%h rbusy=%b busy_vec=%h, want rdata=%h rbusy=%b busy_vec=%h", e.tag, rdata, rbusy, busy_vec, e.rdata, e.rbusy, e.busy_vec); end
    next_cycle();
  endtask

  task automatic test_lifecycle();
    // Allocation must not show combinationally in its own cycle.
    alloc_en = 1'b1; alloc_addr = 5'd7; rd(5'd5, 5'd7);
    push("alloc_r7_same", 32'hDEADBEEF, 32'h0, 2'b00, 32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); n_asserts++;
    if ({rdata, rbusy, busy_vec} !== {e.rdata, e.rbusy, e.busy_vec}) begin n_fail++;
      $display("FAIL %s: got rdata=%h rbusy=%b busy_vec=%h, want rdata=%h rbusy=%b busy_vec=%h", e.tag, rdata, rbusy, busy_vec, e.rdata, e.rbusy, e.busy_vec); end
    next_cycle();
    idle();
    for (int k = 0; k < 3; k++) begin
      push("r7_busy", 32'hDEADBEEF, 32'h0, 2'b01, 32'h80);
      @(negedge clk);
      e = exp_q.pop_front(); n_asserts++;
      if ({rdata, rbusy, busy_vec} !== {e.rdata, e.rbusy, e.busy_vec}) begin n_fail++;
        $display("FAIL %s[%0d]: got rdata=%h rbusy=%b busy_vec=%h, want rdata=%h rbusy=%b busy_vec=%h", e.tag, k, rdata, rbusy, busy_vec, e.rdata, e.rbusy, e.busy_vec); end
      next_cycle();
    end
    wen = 1'b1; waddr = 5'd7; wdata = 32'h55;
    push("r7_retire", 32'hDEADBEEF, 32'h55, 2'b00, 32'h80);
    @(negedge clk);
    e = exp_q.pop_front(); n_asserts++;
    if ({rdata, rbusy, busy_vec} !== {e.rdata, e.rbusy, e.busy_vec}) begin n_fail++;
      $display("FAIL %s: got rdata=%h rbusy=%b busy_vec=%h, want rdata=%h rbusy=%b busy_vec=%h", e.tag, rdata, rbusy, busy_vec, e.rdata, e.rbusy, e.busy_vec); end
    next_cycle();
    idle();
    push("r7_cleared", 32'hDEADBEEF, 32'h55, 2'b00, 32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); n_asserts++;
    if ({rdata, rbusy, busy_vec} !== {e.rdata, e.rbusy, e.busy_vec}) begin n_fail++;
      $display("FAIL %s: got rdata=%h rbusy=%b busy_vec=%h, want rdata=%h rbusy=%b busy_vec=%h", e.tag, rdata, rbusy, busy_vec, e.rdata, e.rbusy, e.busy_vec); end
    next_cycle();
  endtask

  task automatic test_collision_flush();
    alloc_en = 1'b1; alloc_addr = 5'd3; wen = 1'b1; waddr = 5'd3; wdata = 32'hAA;
    rd(5'd3, 5'd3);
    push("collide_same", 32'hAA, 32'hAA, 2'b00, 32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); n_asserts++;
    if ({rdata, rbusy, busy_vec} !== {e.rdata, e.rbusy, e.busy_vec}) begin n_fail++;
      $display("FAIL %s: got rdata=%h rbusy=%b busy_vec=%h, want rdata=%h rbusy=%b busy_vec=%h", e.tag, rdata, rbusy, busy_vec, e.rdata, e.rbusy, e.busy_vec); end
    next_cycle();
    idle();
    push("collide_next", 32'hAA, 32'hAA, 2'b11, 32'h8);
    @(negedge clk);
    e = exp_q.pop_front(); n_asserts++;
    if ({rdata, rbusy, busy_vec} !== {e.rdata, e.rbusy, e.busy_vec}) begin n_fail++;
      $display("FAIL %s: got rdata=%h rbusy=%b busy_vec=%h, want rdata=%h rbusy=%b busy_vec=%h", e.tag, rdata, rbusy, busy_vec, e.rdata, e.rbusy, e.busy_vec); end
    next_cycle();
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd9;
    wen = 1'b1; waddr = 5'd12; wdata = 32'h77; rd(5'd12, 5'd3);
    push("flush_same", 32'h77, 32'hAA, 2'b01, 32'h8);
    @(negedge clk);
    e = exp_q.pop_front(); n_asserts++;
    if ({rdata, rbusy, busy_vec} !== {e.rdata, e.rbusy, e.busy_vec}) begin n_fail++;
      $display("FAIL %s: got rdata=%h rbusy=%b busy_vec=%h, want rdata=%h rbusy=%b busy_vec=%h", e.tag, rdata, rbusy, busy_vec, e.rdata, e.rbusy, e.busy_vec); end
    next_cycle();
    idle();
    push("flush_next", 32'h77, 32'hAA, 2'b00, 32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); n_asserts++;
    if ({rdata, rbusy, busy_vec} !== {e.rdata, e.rbusy, e.busy_vec}) begin n_fail++;
      $display("FAIL %s: got rdata=%h rbusy=%b busy_vec=%h, want rdata=%h rbusy=%b busy_vec=%h", e.tag, rdata, rbusy, busy_vec, e.rdata, e.rbusy, e.busy_vec); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    // Stimulus table: alloc_en, alloc_addr, wen, waddr, wdata per cycle.
    logic          t_al [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [AW-1:0] t_aa [5] = '{5'd1, 5'd2, 5'd4, 5'd0, 5'd0};
    logic          t_we [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [AW-1:0] t_wa [5] = '{5'd0, 5'd0, 5'd1, 5'd2, 5'd0};
    logic [DW-1:0] t_wd [5] = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h0};
    push("b2b_alloc1", 32'h0,  32'h0,  2'b00, 32'h0);
    push("b2b_alloc2", 32'h0,  32'h0,  2'b01, 32'h2);
    push("b2b_ret1",   32'h0,  32'h11, 2'b10, 32'h6);
    push("b2b_ret2",   32'h22, 32'h11, 2'b00, 32'h14);
    push("b2b_idle",   32'h22, 32'h11, 2'b00, 32'h10);
    rd(5'd2, 5'd1);
    for (int c = 0; c < 5; c++) begin
      alloc_en = t_al[c]; alloc_addr = t_aa[c];
      wen = t_we[c]; waddr = t_wa[c]; wdata = t_wd[c];
      @(negedge clk);
      e = exp_q.pop_front(); n_asserts++;
      if ({rdata, rbusy, busy_vec} !== {e.rdata, e.rbusy, e.busy_vec}) begin n_fail++;
        $display("FAIL %s: got rdata=%h rbusy=%b busy_vec=%h, want rdata=%h rbusy=%b busy_vec=%h", e.tag, rdata, rbusy, busy_vec, e.rdata, e.rbusy, e.busy_vec); end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_async_reset();
    rd(5'd4, 5'd5);
    push("pre_reset", 32'h0, 32'hDEADBEEF, 2'b10, 32'h10);
    @(negedge clk);
    e = exp_q.pop_front(); n_asserts++;
    if ({rdata, rbusy, busy_vec} !== {e.rdata, e.rbusy, e.busy_vec}) begin n_fail++;
      $display("FAIL %s: got rdata=%h rbusy=%b busy_vec=%h, want rdata=%h rbusy=%b busy_vec=%h", e.tag, rdata, rbusy, busy_vec, e.rdata, e.rbusy, e.busy_vec); end
    @(posedge clk); #2;
    rst = 1'b0;
    push("async_reset", 32'h0, 32'h0, 2'b00, 32'h0);
    #1;
    e = exp_q.pop_front(); n_asserts++;
    if ({rdata, rbusy, busy_vec} !== {e.rdata, e.rbusy, e.busy_vec}) begin n_fail++;
      $display("FAIL %s: got rdata=%h rbusy=%b busy_vec=%h, want rdata=%h rbusy=%b busy_vec=%h", e.tag, rdata, rbusy, busy_vec, e.rdata, e.rbusy, e.busy_vec); end
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    push("post_reset", 32'h0, 32'h0, 2'b00, 32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); n_asserts++;
    if ({rdata, rbusy, busy_vec} !== {e.rdata, e.rbusy, e.busy_vec}) begin n_fail++;
      $display("FAIL %s: got rdata=%h rbusy=%b busy_vec=%h, want rdata=%h rbusy=%b busy_vec=%h", e.tag, rdata, rbusy, busy_vec, e.rdata, e.rbusy, e.busy_vec); end
    next_cycle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    raddr = '0;
    test_reset();
    test_write_bypass();
    test_reg_zero();
    test_lifecycle();
    test_collision_flush();
    test_back_to_back();
    test_async_reset();
    if (exp_q.size() != 0) begin
      n_asserts++; n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22041211_regfile_sb.md
# ysyx_22041211_regfile_sb

Parametrised multi-read-port integer register file with write-through bypass and a per-register busy scoreboard. It is the next-generation register file for the pipelined NPC core. Decode reads operands and allocates its destination; writeback retires results. The scoreboard gives decode the hazard signal it needs to stall. Architectural register 0 is hardwired to zero.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits.
- NUM_REGS, 32, architectural registers (16 for RV32E); power of two, ≥ 2.
- NUM_RD, 2, number of read ports, 1..4.
- AW, $clog2(NUM_REGS), register address width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- wen  in  1  writeback enable.
- waddr  in  AW  writeback destination.
- wdata  in  DATA_WIDTH  writeback data.
- raddr  in  NUM_RD*AW  read addresses; port i at bits [i*AW +: AW].
- rdata  out  NUM_RD*DATA_WIDTH  read data; port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- rbusy  out  NUM_RD  port i's source has an outstanding (unretired) producer.
- alloc_en  in  1  decode issues an instruction that writes alloc_addr.
- alloc_addr  in  AW  destination being allocated.
- flush  in  1  pipeline flush; clears all busy bits.
- busy_vec  out  NUM_REGS  raw scoreboard state, for debug/difftest.

## Operation
- Storage:
  - rf[NUM_REGS] of DATA_WIDTH bits.
  - busy[NUM_REGS] of 1 bit.
- Reset (rst low, asynchronous): all rf entries are 0 and all busy bits are 0. Consequently, during reset:
  - rdata reads 0.
  - rbusy is 0.
  - busy_vec is 0.
- Write: on the clock edge with wen=1 and waddr≠0, rf[waddr] takes wdata. Writes to register 0 are discarded.
- Read: combinational.
  - rdata_i = 0 if raddr_i==0.
  - Otherwise rdata_i = wdata if wen and waddr==raddr_i (bypass).
  - Otherwise rdata_i = rf[raddr_i].
- rbusy_i (combinational) = busy[raddr_i] & ~(wen & waddr==raddr_i). It is always 0 for register 0.
- Scoreboard next-state per register r, in priority order:
  1. flush → 0.
  2. alloc_en & alloc_addr==r & r≠0 → 1.
  3. wen & waddr==r → 0.
  4. Otherwise hold.
- Simultaneous alloc and writeback to the same register: busy ends at 1, because the new producer wins. The data write still happens.
- Writeback to a non-busy register is legal and updates data; busy stays 0.
- alloc_en with alloc_addr==0 has no effect.
- flush together with alloc_en: the allocation is dropped. flush does not block a same-cycle data write.
- One outstanding producer per register is tracked. Decode must stall on rbusy, or on busy[rd] for WAW, before allocating.

## Timing
- Read latency 0: rdata and rbusy are combinational from raddr, wen, waddr, wdata and state.
- Write latency 1: data is visible in rf after the edge, and visible at rdata in the same cycle through the bypass.
- Scoreboard latency 1:
  - An allocation made in cycle n shows rbusy=1 from cycle n+1.
  - A retirement in cycle n clears rbusy combinationally in cycle n.
- Reset deassertion: the first functional edge is the first rising clk after rst goes high. Reset asserted mid-operation clears state immediately, independent of clk.
- No combinational path from alloc_en or alloc_addr to any output.

## Structure
- Shared package ysyx_22041211_pkg holds the DATA_WIDTH and NUM_REGS defaults and a REG_ZERO address constant.
- Sub-module ysyx_22041211_scoreboard (NUM_REGS, AW) owns the busy[] bits, the priority update and busy_vec. The top level instantiates it and generates the NUM_RD read/bypass muxes.

## Test plan
- Reset then read: hold rst low, then release. raddr={5,0} → rdata={0,0}, rbusy=0, busy_vec=0.
- Write and bypass: wen=1, waddr=5, wdata=0xDEADBEEF, raddr0=5 in the same cycle → rdata0=0xDEADBEEF that cycle. The following cycle with wen=0 → still 0xDEADBEEF.
- Register 0: wen=1, waddr=0, wdata=0x1234 and alloc_en=1, alloc_addr=0 → rdata for raddr 0 reads 0, busy_vec[0]=0.
- Scoreboard lifecycle:
  - Alloc r7 in cycle 1 → rbusy=1 for raddr 7 in cycles 2..k.
  - Writeback r7=0x55 in cycle k → rbusy=0 and rdata=0x55 in cycle k. busy_vec[7]=0 in cycle k+1.
- Collision and flush:
  - Alloc r3 and writeback r3 in the same cycle → busy_vec[3]=1 next cycle.
  - flush with alloc r9 → busy_vec all 0 next cycle.
- Async reset mid-run: registers loaded and busy set, rst pulsed low between clock edges → all outputs 0 before the next clk edge.
